// File: rtl/change_dispenser_if.sv
// Handshake bundle between the payout controller (master) and the change dispenser (slave).
// Carries the start/amount request, the hopper handshake and the payout status.
interface change_dispenser_if;
    logic       start;
    logic [3:0] change_amount;
    logic       hopper_ack;
    logic       hopper_500_empty;
    logic       hopper_100_empty;
    logic       coin_out_500;
    logic       coin_out_100;
    logic       busy;
    logic       done;
    logic       error;
    logic [3:0] remaining;
    logic [3:0] coins_dispensed;

    modport master (
        output start, change_amount, hopper_ack, hopper_500_empty, hopper_100_empty,
        input  coin_out_500, coin_out_100, busy, done, error, remaining, coins_dispensed
    );

    modport slave (
        input  start, change_amount, hopper_ack, hopper_500_empty, hopper_100_empty,
        output coin_out_500, coin_out_100, busy, done, error, remaining, coins_dispensed
    );
endinterface

// File: rtl/change_dispenser.sv
// Pays out change in 500/100 coins via a hopper handshake, preferring 500 coins,
// with a per-coin ack timeout, an inter-coin gap and a sticky fault state.
module change_dispenser #(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned GAP_CYCLES     = 2
) (
    input logic               clock,
    input logic               reset,
    change_dispenser_if.slave bus
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
    localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle, StSelect, StEject, StGap, StDone, StFault
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      rem_q, rem_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            c500_q, c500_d;
    logic            c100_q, c100_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [GapW-1:0] gap_q, gap_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            rem_q   <= '0;
            cnt_q   <= '0;
            c500_q  <= 1'b0;
            c100_q  <= 1'b0;
            tmo_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            c500_q  <= c500_d;
            c100_q  <= c100_d;
            tmo_q   <= tmo_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        c500_d  = c500_q;
        c100_d  = c100_q;
        tmo_d   = tmo_q;
        gap_d   = gap_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    rem_d   = bus.change_amount;
                    cnt_d   = '0;
                    state_d = StSelect;
                end
            end
            StSelect: begin
                tmo_d = '0;
                if (rem_q >= 4'd5 && !bus.hopper_500_empty) begin
                    c500_d  = 1'b1;
                    state_d = StEject;
                end else if (rem_q != 4'd0 && !bus.hopper_100_empty) begin
                    c100_d  = 1'b1;
                    state_d = StEject;
                end else if (rem_q != 4'd0) begin
                    state_d = StFault;
                end else begin
                    state_d = StDone;
                end
            end
            StEject: begin
                // An ack arriving in the expiry cycle still completes the coin.
                if (bus.hopper_ack) begin
                    c500_d  = 1'b0;
                    c100_d  = 1'b0;
                    rem_d   = c500_q ? rem_q - 4'd5 : rem_q - 4'd1;
                    cnt_d   = (cnt_q == 4'hf) ? cnt_q : cnt_q + 4'd1;
                    gap_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? StSelect : StGap;
                end else if (tmo_q == TmoLast) begin
                    c500_d  = 1'b0;
                    c100_d  = 1'b0;
                    state_d = StFault;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StSelect;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            StFault: state_d = StFault;
            default: state_d = StIdle;
        endcase
    end

    assign bus.coin_out_500    = c500_q;
    assign bus.coin_out_100    = c100_q;
    assign bus.busy            = (state_q != StIdle) && (state_q != StFault);
    assign bus.done            = (state_q == StDone);
    assign bus.error           = (state_q == StFault);
    assign bus.remaining       = rem_q;
    assign bus.coins_dispensed = cnt_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomised self-checking bench for change_dispenser: a hopper responder drives acks and a
// greedy payout model predicts the coin sequence, final balance, count and fault outcome.
module tb_change_dispenser;

    localparam int unsigned Tmo = 8;
    localparam int unsigned Gap = 2;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    change_dispenser_if bus ();

    change_dispenser #(
        .TIMEOUT_CYCLES(Tmo),
        .GAP_CYCLES    (Gap)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    task automatic do_reset();
        bus.start      = 1'b0;
        bus.hopper_ack = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    // Drives one payout and checks it against the greedy payout model.
    task automatic run_payout(input string name, input int amt, input bit e500, input bit e100,
                              input int dmin, input int dmax, input bit no_ack, input bit inject);
        int exp_q[$];
        int obs_q[$];
        int rem, paid, coin, cyc, cd, first_req, done_cnt, done_cyc, busy_cnt;
        int low_run, cur_hi, max_hi, post, bad_idx;
        bit fault, req, req_prev, both_hi, gap_bad, term, finished, restarted, e500_bad;

        rem = amt; paid = 0; fault = 1'b0;
        while (rem > 0 && !fault) begin
            coin = (rem >= 5 && !e500) ? 5 : (!e100 ? 1 : 0);
            if (coin == 0) fault = 1'b1;
            else begin
                exp_q.push_back(coin);
                if (no_ack) fault = 1'b1;
                else begin
                    rem  -= coin;
                    paid += 1;
                end
            end
        end

        cyc = 0; cd = 0; first_req = -1; done_cnt = 0; done_cyc = -1; busy_cnt = 0;
        low_run = 0; cur_hi = 0; max_hi = 0; post = 0;
        req_prev = 0; both_hi = 0; gap_bad = 0; term = 0; finished = 0; restarted = 0;
        e500_bad = 0;

        bus.hopper_500_empty = e500;
        bus.hopper_100_empty = e100;
        @(negedge clock);
        bus.start         = 1'b1;
        bus.change_amount = amt[3:0];

        for (int i = 0; i < 400 && !finished; i++) begin
            @(negedge clock);
            cyc++;
            bus.start      = 1'b0;
            bus.hopper_ack = 1'b0;
            req = bus.coin_out_500 || bus.coin_out_100;
            if (bus.coin_out_500 && bus.coin_out_100) both_hi = 1'b1;
            if (bus.coin_out_500 && e500) e500_bad = 1'b1;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (req) begin
                cur_hi++;
                if (cur_hi > max_hi) max_hi = cur_hi;
                if (!req_prev) begin
                    obs_q.push_back(bus.coin_out_500 ? 5 : 1);
                    if (first_req < 0) first_req = cyc;
                    if (obs_q.size() > 1 && low_run < Gap) gap_bad = 1'b1;
                    cd = $urandom_range(dmax, dmin);
                    if (inject && !restarted) begin
                        bus.start         = 1'b1;
                        bus.change_amount = 4'hf;
                        restarted         = 1'b1;
                    end
                end
                if (!no_ack) begin
                    if (cd == 0) bus.hopper_ack = 1'b1;
                    else cd--;
                end
                low_run = 0;
            end else begin
                cur_hi = 0;
                low_run++;
                if (inject && req_prev) bus.hopper_ack = 1'b1;
            end
            req_prev = req;
            if (bus.done || bus.error) term = 1'b1;
            if (term) begin
                post++;
                if (post >= 4) finished = 1'b1;
            end
        end

        n_checks++;
        if (!finished) begin
            n_fail++;
            $display("FAIL %s completion: no done/error within cycle budget", name);
        end
        bad_idx = -1;
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
            if (bad_idx < 0 && exp_q[k] != obs_q[k]) bad_idx = k;
        n_checks++;
        if (obs_q.size() != exp_q.size() || bad_idx >= 0) begin
            n_fail++;
            $display("FAIL %s coin_sequence: got %0d coins (first diff %0d) expected %0d coins",
                     name, obs_q.size(), bad_idx, exp_q.size());
        end
        n_checks++;
        if (bus.remaining !== 4'(rem)) begin
            n_fail++;
            $display("FAIL %s remaining: got %0d expected %0d", name, bus.remaining, rem);
        end
        n_checks++;
        if (bus.coins_dispensed !== 4'((paid > 15) ? 15 : paid)) begin
            n_fail++;
            $display("FAIL %s coins_dispensed: got %0d expected %0d", name,
                     bus.coins_dispensed, paid);
        end
        n_checks++;
        if (bus.error !== fault) begin
            n_fail++;
            $display("FAIL %s error: got %b expected %b", name, bus.error, fault);
        end
        n_checks++;
        if (done_cnt != (fault ? 0 : 1)) begin
            n_fail++;
            $display("FAIL %s done_cycles: got %0d expected %0d", name, done_cnt, fault ? 0 : 1);
        end
        n_checks++;
        if (both_hi || e500_bad) begin
            n_fail++;
            $display("FAIL %s request_legality: both_high=%b 500_while_empty=%b expected 0/0",
                     name, both_hi, e500_bad);
        end
        n_checks++;
        if (gap_bad) begin
            n_fail++;
            $display("FAIL %s gap: got fewer than %0d low cycles between requests", name, Gap);
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            if (first_req != 2) begin
                n_fail++;
                $display("FAIL %s first_request_latency: got %0d expected 2", name, first_req);
            end
        end
        if (amt == 0) begin
            n_checks++;
            if (done_cyc != 2 || busy_cnt != 2) begin
                n_fail++;
                $display("FAIL %s zero_amount: done_cycle=%0d busy=%0d expected 2 and 2",
                         name, done_cyc, busy_cnt);
            end
        end
        if (no_ack && exp_q.size() > 0) begin
            n_checks++;
            if (max_hi != Tmo) begin
                n_fail++;
                $display("FAIL %s request_hold: got %0d cycles expected %0d", name, max_hi, Tmo);
            end
            bus.start         = 1'b1;
            bus.change_amount = 4'hf;
            @(negedge clock);
            bus.start = 1'b0;
            repeat (3) @(negedge clock);
            n_checks++;
            if (bus.error !== 1'b1 || bus.busy !== 1'b0 || bus.remaining !== 4'(amt) ||
                bus.coin_out_100 !== 1'b0 || bus.coin_out_500 !== 1'b0) begin
                n_fail++;
                $display("FAIL %s fault_sticky: err=%b busy=%b rem=%0d expected 1 0 %0d",
                         name, bus.error, bus.busy, bus.remaining, amt);
            end
        end
        if (fault) do_reset();
    endtask

    task automatic test_reset();
        reset                = 1'b1;
        bus.start            = 1'b0;
        bus.change_amount    = 4'd0;
        bus.hopper_ack       = 1'b0;
        bus.hopper_500_empty = 1'b0;
        bus.hopper_100_empty = 1'b0;
        #2 reset = 1'b0;
        #2;
        n_checks++;
        if ({bus.coin_out_500, bus.coin_out_100, bus.busy, bus.done, bus.error} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {bus.coin_out_500, bus.coin_out_100, bus.busy, bus.done, bus.error});
        end
        n_checks++;
        if (bus.remaining !== 4'd0 || bus.coins_dispensed !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_counts: got rem=%0d coins=%0d expected 0 0",
                     bus.remaining, bus.coins_dispensed);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_busy: got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_change_7();
        run_payout("change_7", 7, 1'b0, 1'b0, 3, 3, 1'b0, 1'b0);
    endtask

    task automatic test_zero();
        run_payout("zero", 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_no_500();
        run_payout("no_500", 10, 1'b1, 1'b0, 0, 2, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        run_payout("timeout", 3, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_empty_fault();
        run_payout("empty_fault", 8, 1'b0, 1'b1, 0, 1, 1'b0, 1'b0);
    endtask

    task automatic test_ignored_inputs();
        run_payout("ignored_inputs", 5, 1'b0, 1'b0, 1, 2, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_eject();
        int  waited;
        bit  seen;
        bus.hopper_500_empty = 1'b0;
        bus.hopper_100_empty = 1'b0;
        @(negedge clock);
        bus.start         = 1'b1;
        bus.change_amount = 4'd6;
        @(negedge clock);
        bus.start = 1'b0;
        seen = 1'b0;
        waited = 0;
        while (!seen && waited < 10) begin
            @(negedge clock);
            waited++;
            seen = bus.coin_out_500;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL mid_eject_request: got no 500 request expected one");
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (bus.coin_out_500 !== 1'b0 || bus.busy !== 1'b0 || bus.remaining !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_eject_async_drop: c500=%b busy=%b rem=%0d expected 0 0 0",
                     bus.coin_out_500, bus.busy, bus.remaining);
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++;
        if ({bus.coin_out_500, bus.coin_out_100, bus.busy, bus.done, bus.error} !== 5'b0 ||
            bus.remaining !== 4'd0 || bus.coins_dispensed !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_eject_after_release: flags=%b rem=%0d coins=%0d expected all 0",
                     {bus.coin_out_500, bus.coin_out_100, bus.busy, bus.done, bus.error},
                     bus.remaining, bus.coins_dispensed);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            run_payout("random", int'($urandom_range(15, 0)), $urandom_range(3, 0) == 0,
                       $urandom_range(5, 0) == 0, 0, 5, 1'b0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_change_7();
        test_zero();
        test_no_500();
        test_timeout();
        test_empty_fault();
        test_ignored_inputs();
        test_reset_mid_eject();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning max cycles a coin request waits for hopper_ack before fault.
REQ-002 SHALL have parameter GAP_CYCLES, default 2, meaning idle cycles between consecutive coin requests.
REQ-003 SHALL have port: clock  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port: start  input  1  begin payout of change_amount; sampled in IDLE only.
REQ-006 SHALL have port: change_amount  input  4  change owed in units of 100 (0..15).
REQ-007 SHALL have port: hopper_ack  input  1  one-cycle pulse, hopper ejected the requested coin.
REQ-008 SHALL have port: hopper_500_empty  input  1  500 tube empty.
REQ-009 SHALL have port: hopper_100_empty  input  1  100 tube empty.
REQ-010 SHALL have port: coin_out_500  output  1  request ejection of one 500 coin.
REQ-011 SHALL have port: coin_out_100  output  1  request ejection of one 100 coin.
REQ-012 SHALL have port: busy  output  1  high in every state except IDLE and FAULT.
REQ-013 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port: error  output  1  sticky fault flag.
REQ-015 SHALL have port: remaining  output  4  change still owed, units of 100.
REQ-016 SHALL have port: coins_dispensed  output  4  coins ejected in current payout, saturating at 15.

Function
REQ-017 SHALL implement states IDLE, SELECT, EJECT, GAP, DONE, FAULT.
REQ-018 IDLE: start=1 latches change_amount into remaining, clears coins_dispensed, moves to SELECT next edge; start ignored in all other states.
REQ-019 SELECT (one cycle): remaining>=5 and !hopper_500_empty -> EJECT(500); else remaining>=1 and !hopper_100_empty -> EJECT(100); else remaining>=1 -> FAULT; else remaining=0 -> DONE.
REQ-020 SELECT with hopper_500_empty SHALL substitute 100 coins; no 500 coin is ever requested while hopper_500_empty=1.
REQ-021 EJECT: exactly one of coin_out_500/coin_out_100 registered high, held until hopper_ack or timeout; never both high.
REQ-022 EJECT on hopper_ack: request drops next cycle, remaining decrements by 5 or 1, coins_dispensed increments, go to GAP.
REQ-023 hopper_ack outside EJECT SHALL be ignored.
REQ-024 EJECT timeout counter starts at 0 on entry; reaching TIMEOUT_CYCLES without ack -> FAULT; ack in the expiry cycle wins (normal completion).
REQ-025 GAP: requests low for GAP_CYCLES cycles, then SELECT.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE; change_amount=0 reaches DONE with no coin requests.
REQ-027 Latency: start at edge N -> SELECT after N, first coin request visible after edge N+1.
REQ-028 FAULT: error=1, requests low, busy=0, remaining holds unpaid amount; exit only via reset.
REQ-029 remaining SHALL never underflow; subtraction only per REQ-019 conditions.

Reset
REQ-030 reset=0 SHALL asynchronously force IDLE and drive coin_out_500=0, coin_out_100=0, busy=0, done=0, error=0, remaining=0, coins_dispensed=0, timeout and gap counters=0.
REQ-031 Reset mid-EJECT SHALL drop the coin request immediately, without waiting for a clock edge; an unpaid balance is discarded.

Verification
REQ-032 change_amount=7, start, ack 3 cycles after each request -> one 500 then two 100 requests, done pulse, remaining=0, coins_dispensed=3, error=0.
REQ-033 change_amount=0, start at edge N -> done=1 for one cycle after edge N+1, no coin_out pulses, busy high for 2 cycles.
REQ-034 change_amount=10, hopper_500_empty=1 -> exactly ten 100 requests separated by >=GAP_CYCLES low cycles, coins_dispensed=10.
REQ-035 change_amount=3, hopper_ack never asserted, TIMEOUT_CYCLES=8 -> coin_out_100 high 8 cycles, then error=1, busy=0, remaining=3; start ignored until reset.
REQ-036 change_amount=6, reset=0 asserted during first EJECT between edges -> coin_out_500 falls combinationally after the reset edge; after release, IDLE with all outputs 0.
REQ-037 start pulsed again during payout of 5, and a stray hopper_ack during GAP -> both ignored; exactly one 500 coin paid, remaining=0.
